// File: rtl/ppu_pkg.sv
// Shared PPU types: 2-bit colour index, background FIFO states, tile row width.
package ppu_pkg;

  typedef logic [1:0] pixel_t;

  typedef enum logic [1:0] {IDLE, DISCARD, RUN} bg_fifo_state_t;

  localparam int unsigned TILE_ROW_PIXELS = 8;

endpackage

// File: rtl/bg_pixel_fifo_if.sv
// Fetcher push / mixer pop bundle for the background pixel FIFO.
interface bg_pixel_fifo_if;
  import ppu_pkg::*;

  logic                              push_valid_in;
  pixel_t [TILE_ROW_PIXELS-1:0]      push_pixels_in;
  logic                              empty_out;
  logic                              pop_en_in;
  pixel_t                            pixel_out;
  logic                              pixel_valid_out;
  logic                              overflow_out;

  modport master (
    output push_valid_in, push_pixels_in, pop_en_in,
    input  empty_out, pixel_out, pixel_valid_out, overflow_out
  );

  modport slave (
    input  push_valid_in, push_pixels_in, pop_en_in,
    output empty_out, pixel_out, pixel_valid_out, overflow_out
  );

endinterface

// File: rtl/bg_pixel_fifo.sv
// Background pixel FIFO: takes 8-pixel tile rows, shifts one pixel per T-cycle,
// handles SCX fine-scroll discard at line start and the window-start flush.
module bg_pixel_fifo
  import ppu_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        tclk_en_in,
  input  logic        line_start_in,
  input  logic [2:0]  scx_fine_in,
  input  logic        clear_in,
  bg_pixel_fifo_if.slave bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW-1:0] PUSH_LIMIT = CW'(DEPTH - TILE_ROW_PIXELS);

  bg_fifo_state_t  state_q, state_d;
  logic [2:0]      discard_q, discard_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
  pixel_t          pixel_q, pixel_d;
  logic            valid_q, valid_d;
  logic            ovf_q, ovf_d;
  logic            push_acc, pop;
  pixel_t          mem [DEPTH];

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    count_d   = count_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    pixel_d   = pixel_q;
    valid_d   = 1'b0;
    ovf_d     = 1'b0;
    push_acc  = 1'b0;
    pop       = 1'b0;
    if (line_start_in) begin
      state_d   = (scx_fine_in != '0) ? DISCARD : RUN;
      discard_d = scx_fine_in;
      count_d   = '0;
      rd_d      = '0;
      wr_d      = '0;
    end else if (clear_in) begin
      state_d   = RUN;
      discard_d = '0;
      count_d   = '0;
      rd_d      = '0;
      wr_d      = '0;
    end else begin
      // Push and pop both judge the pre-tick count, so an empty FIFO never pops its own push.
      push_acc = bus.push_valid_in && (count_q <= PUSH_LIMIT);
      ovf_d    = bus.push_valid_in && !push_acc;
      case (state_q)
        DISCARD: pop = (count_q != '0);
        RUN:     pop = bus.pop_en_in && (count_q != '0);
        default: pop = 1'b0;
      endcase
      if (pop) begin
        rd_d = rd_q + 1'b1;
        if (state_q == RUN) begin
          pixel_d = mem[rd_q];
          valid_d = 1'b1;
        end else begin
          discard_d = discard_q - 3'd1;
          if (discard_q == 3'd1) state_d = RUN;
        end
      end
      if (push_acc) wr_d = wr_q + PW'(TILE_ROW_PIXELS);
      count_d = count_q + (push_acc ? CW'(TILE_ROW_PIXELS) : '0) - (pop ? CW'(1) : '0);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= IDLE;
      discard_q <= '0;
      count_q   <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      pixel_q   <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (tclk_en_in) begin
      state_q   <= state_d;
      discard_q <= discard_d;
      count_q   <= count_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      pixel_q   <= pixel_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (tclk_en_in && push_acc) begin
      for (int unsigned i = 0; i < TILE_ROW_PIXELS; i++) begin
        mem[wr_q + PW'(i)] <= bus.push_pixels_in[i];
      end
    end
  end

  assign bus.empty_out       = (count_q == '0);
  assign bus.pixel_out       = pixel_q;
  assign bus.pixel_valid_out = valid_q;
  assign bus.overflow_out    = ovf_q;

endmodule

// File: tb/tb_bg_pixel_fifo.sv
// Directed bench for bg_pixel_fifo with a queue-based reference scoreboard.
module tb_bg_pixel_fifo;
  import ppu_pkg::*;

  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tclk_en = 1'b0;
  logic       line_start = 1'b0;
  logic [2:0] scx_fine = '0;
  logic       clear = 1'b0;

  bg_pixel_fifo_if bus ();

  bg_pixel_fifo #(.DEPTH(DEPTH)) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .tclk_en_in    (tclk_en),
    .line_start_in (line_start),
    .scx_fine_in   (scx_fine),
    .clear_in      (clear),
    .bus           (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  pixel_t         m_q[$];
  bg_fifo_state_t m_st = IDLE;
  int             m_d = 0;
  pixel_t         last_pix = '0;
  bit             last_valid = 1'b0;

  pixel_t [7:0] row_a, row_b, row_c, row_z;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One T-cycle: drive inputs, advance the reference model, then compare outputs.
  task automatic tick(input string tag, input bit pv, input pixel_t [7:0] px, input bit pe,
                      input bit ls = 1'b0, input logic [2:0] scx = '0, input bit clr = 1'b0);
    bit exp_ovf;
    int pre;
    pixel_t p;
    bus.push_valid_in  = pv;
    bus.push_pixels_in = px;
    bus.pop_en_in      = pe;
    line_start         = ls;
    scx_fine           = scx;
    clear              = clr;
    tclk_en            = 1'b1;
    exp_ovf            = 1'b0;
    last_valid         = 1'b0;
    if (ls) begin
      m_q.delete();
      m_st = (scx != 0) ? DISCARD : RUN;
      m_d  = int'(scx);
    end else if (clr) begin
      m_q.delete();
      m_st = RUN;
      m_d  = 0;
    end else begin
      pre = m_q.size();
      if (pre > 0 && (m_st == DISCARD || (m_st == RUN && pe))) begin
        p = m_q.pop_front();
        if (m_st == RUN) begin
          last_pix   = p;
          last_valid = 1'b1;
        end else begin
          m_d--;
          if (m_d == 0) m_st = RUN;
        end
      end
      if (pv) begin
        if (pre <= int'(DEPTH) - 8) begin
          for (int i = 0; i < 8; i++) m_q.push_back(px[i]);
        end else begin
          exp_ovf = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, 32'(bus.pixel_valid_out), 32'(last_valid));
    chk({tag, ".pixel"}, 32'(bus.pixel_out), 32'(last_pix));
    chk({tag, ".ovf"},   32'(bus.overflow_out), 32'(exp_ovf));
    chk({tag, ".empty"}, 32'(bus.empty_out), 32'(m_q.size() == 0));
  endtask

  initial begin
    int ra[8] = '{0, 1, 2, 3, 3, 2, 1, 0};
    int rb[8] = '{3, 3, 0, 1, 2, 2, 1, 0};
    for (int i = 0; i < 8; i++) begin
      row_a[i] = pixel_t'(ra[i]);
      row_b[i] = pixel_t'(rb[i]);
      row_c[i] = pixel_t'($urandom_range(3, 0));
      row_z[i] = '0;
    end
    bus.push_valid_in  = 1'b0;
    bus.push_pixels_in = row_z;
    bus.pop_en_in      = 1'b0;

    // Reset state, no clock edge yet
    #2;
    chk("reset.pixel", 32'(bus.pixel_out), 32'd0);
    chk("reset.valid", 32'(bus.pixel_valid_out), 32'd0);
    chk("reset.ovf",   32'(bus.overflow_out), 32'd0);
    chk("reset.empty", 32'(bus.empty_out), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic row through, scx=0
    tick("ls0", 0, row_z, 0, 1'b1, 3'd0);
    tick("pushA", 1, row_a, 0);
    for (int i = 0; i < 8; i++) tick("popA", 0, row_z, 1);
    tick("popEmpty", 0, row_z, 1);

    // Fine-scroll discard of 3 pixels
    tick("ls3", 0, row_z, 1, 1'b1, 3'd3);
    tick("pushD", 1, row_a, 1);
    for (int i = 0; i < 9; i++) tick("popD", 0, row_z, 1);
    chk("discard.state", 32'(dut.state_q), 32'(RUN));

    // Fill to DEPTH, then overflow at count 9
    tick("ls0b", 0, row_z, 0, 1'b1, 3'd0);
    tick("fill1", 1, row_a, 0);
    tick("fill2", 1, row_b, 0);
    for (int i = 0; i < 7; i++) tick("pop7", 0, row_z, 1);
    tick("ovf", 1, row_c, 0);
    tick("ovfEnd", 0, row_z, 0);

    // count=1 with simultaneous push and pop
    for (int i = 0; i < 8; i++) tick("pop8", 0, row_z, 1);
    tick("pushPop", 1, row_c, 1);
    for (int i = 0; i < 9; i++) tick("drainC", 0, row_z, 1);

    // Window clear at count=5 with a same-tick push
    tick("pushE", 1, row_b, 0);
    for (int i = 0; i < 3; i++) tick("pop3", 0, row_z, 1);
    tick("clear", 1, row_a, 0, 1'b0, 3'd0, 1'b1);
    tick("popAfterClr", 0, row_z, 1);

    // T-cycle enable low holds outputs mid-pop
    tick("pushH", 1, row_b, 0);
    tick("popH1", 0, row_z, 1);
    tick("popH2", 0, row_z, 1);
    tclk_en = 1'b0;
    bus.pop_en_in = 1'b1;
    bus.push_valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("hold.pixel", 32'(bus.pixel_out), 32'(last_pix));
      chk("hold.valid", 32'(bus.pixel_valid_out), 32'd1);
      chk("hold.ovf",   32'(bus.overflow_out), 32'd0);
    end
    tick("popH3", 0, row_z, 1);

    // Async reset mid-row with the enable low
    tclk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset.pixel", 32'(bus.pixel_out), 32'd0);
    chk("areset.valid", 32'(bus.pixel_valid_out), 32'd0);
    chk("areset.empty", 32'(bus.empty_out), 32'd1);
    m_q.delete();
    m_st = IDLE;
    m_d = 0;
    last_pix = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // IDLE stores pushes but ignores pops
    tick("idlePush", 1, row_a, 1);
    tick("idlePop", 0, row_z, 1);
    tick("ls0c", 0, row_z, 0, 1'b1, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
